l2c_dl1_port: RTL and testbench



---
 rtl/l2c_dl1_pkg.sv | 26 ++
 rtl/l2c_dl1_port_if.sv | 61 ++++++
 rtl/l2c_inv_fifo.sv | 57 +++++
 rtl/l2c_dl1_port.sv | 141 ++++++++++++++
 tb/tb_l2c_dl1_port.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2c_dl1_pkg.sv
// Shared types and constants for the L2C-side DL1 port.
package l2c_dl1_pkg;

  // Request FSM states
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StData,
    StDone
  } req_state_e;

  // DL1 flags value that marks a cacheable access
  localparam logic [1:0] CACHEABLE_FLAGS = 2'b10;

  // Byte-offset bits within one 32-bit word
  localparam int unsigned WORD_OFF_W = 2;

  // Byte-offset bits within a line of the given number of words
  function automatic int unsigned line_off_w(int unsigned line_words);
    return $clog2(line_words) + WORD_OFF_W;
  endfunction

  // Line offset width for the default 8-word line
  localparam int unsigned LINE_OFF_W = 5;

endpackage

// File: rtl/l2c_dl1_port_if.sv
// DL1 request/refill/invalidate bus plus the L2C backend and invalidation source.
// The slave modport is the responder (l2c_dl1_port); master is its environment.
interface l2c_dl1_port_if;

  // DL1 request side
  logic [31:0] i_dl1_adr;
  logic [1:0]  i_dl1_flags;
  logic [3:0]  i_dl1_ben;
  logic        i_dl1_wen;
  logic [31:0] i_dl1_wdata;
  logic        i_dl1_valid;
  logic [31:0] o_dl1_rdata;
  logic        o_dl1_rdata_valid;
  logic        o_dl1_tlb_fault;
  logic        o_dl1_stall;

  // DL1 invalidation side
  logic [31:0] o_dl1_inv_adr;
  logic        o_dl1_inv_req;
  logic        i_dl1_inv_ack;

  // L2C backend
  logic        o_be_req;
  logic [31:0] o_be_adr;
  logic        o_be_wen;
  logic [3:0]  o_be_ben;
  logic [31:0] o_be_wdata;
  logic        o_be_line;
  logic        i_be_ack;
  logic [31:0] i_be_rdata;
  logic        i_be_rdata_valid;
  logic        i_be_fault;

  // Invalidation source
  logic [31:0] i_inv_adr;
  logic        i_inv_push;
  logic        o_inv_full;

  modport slave (
    input  i_dl1_adr, i_dl1_flags, i_dl1_ben, i_dl1_wen, i_dl1_wdata, i_dl1_valid,
    output o_dl1_rdata, o_dl1_rdata_valid, o_dl1_tlb_fault, o_dl1_stall,
    output o_dl1_inv_adr, o_dl1_inv_req,
    input  i_dl1_inv_ack,
    output o_be_req, o_be_adr, o_be_wen, o_be_ben, o_be_wdata, o_be_line,
    input  i_be_ack, i_be_rdata, i_be_rdata_valid, i_be_fault,
    input  i_inv_adr, i_inv_push,
    output o_inv_full
  );

  modport master (
    output i_dl1_adr, i_dl1_flags, i_dl1_ben, i_dl1_wen, i_dl1_wdata, i_dl1_valid,
    input  o_dl1_rdata, o_dl1_rdata_valid, o_dl1_tlb_fault, o_dl1_stall,
    input  o_dl1_inv_adr, o_dl1_inv_req,
    output i_dl1_inv_ack,
    input  o_be_req, o_be_adr, o_be_wen, o_be_ben, o_be_wdata, o_be_line,
    output i_be_ack, i_be_rdata, i_be_rdata_valid, i_be_fault,
    output i_inv_adr, i_inv_push,
    input  o_inv_full
  );

endinterface

// File: rtl/l2c_inv_fifo.sv
// Count-based invalidation address FIFO; push and pop may happen in the same cycle.
// A push while full and a pop while empty are ignored.
module l2c_inv_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  // Head is forced to zero when empty so the address bus is clean after reset
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && valid_o;

  // Storage write on accepted push
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/l2c_dl1_port.sv
// L2C-side responder for DL1: forwards word reads/writes and line fills to the
// backend, replays beats/faults in the DL1 stall/valid pattern, and queues invalidations.
module l2c_dl1_port
  import l2c_dl1_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned INV_DEPTH  = 4
) (
  input logic           clk_mc,
  input logic           rst_mc_n,
  l2c_dl1_port_if.slave bus
);

  localparam int unsigned LineOffW = line_off_w(LINE_WORDS);
  localparam int unsigned CntW     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [31:0] LineMask = ~((32'd1 << LineOffW) - 32'd1);

  req_state_e      state_q;
  logic [31:0]     adr_q, wdata_q, rdata_q;
  logic [3:0]      ben_q;
  logic            wen_q, line_q;
  logic [CntW-1:0] cnt_q;
  logic            be_req_q, stall_q, rdata_valid_q, fault_q;
  logic            skip_q;
  logic            is_line, last_beat;

  assign is_line   = (bus.i_dl1_flags == CACHEABLE_FLAGS) && !bus.i_dl1_wen;
  assign last_beat = !line_q || (cnt_q == CntW'(LINE_WORDS - 1));

  // Request FSM with all DL1/backend outputs registered
  always_ff @(posedge clk_mc) begin
    if (!rst_mc_n) begin
      state_q       <= StIdle;
      adr_q         <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      ben_q         <= '0;
      wen_q         <= 1'b0;
      line_q        <= 1'b0;
      cnt_q         <= '0;
      be_req_q      <= 1'b0;
      stall_q       <= 1'b1;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      skip_q        <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // DL1 is still dropping valid in the first Idle cycle after Done
          skip_q <= 1'b0;
          if (bus.i_dl1_valid && !skip_q) begin
            line_q   <= is_line;
            adr_q    <= is_line ? (bus.i_dl1_adr & LineMask) : bus.i_dl1_adr;
            wen_q    <= bus.i_dl1_wen;
            ben_q    <= bus.i_dl1_ben;
            wdata_q  <= bus.i_dl1_wdata;
            be_req_q <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (bus.i_be_fault) begin
            be_req_q <= 1'b0;
            fault_q  <= 1'b1;
            stall_q  <= 1'b0;
            state_q  <= StDone;
          end else if (bus.i_be_ack) begin
            be_req_q <= 1'b0;
            cnt_q    <= '0;
            if (wen_q) begin
              stall_q <= 1'b0;
              state_q <= StDone;
            end else if (bus.i_be_rdata_valid) begin
              // First beat arriving with the ack counts as beat 0
              rdata_q       <= bus.i_be_rdata;
              rdata_valid_q <= 1'b1;
              if (!line_q || LINE_WORDS == 1) begin
                stall_q <= 1'b0;
                state_q <= StDone;
              end else begin
                cnt_q   <= CntW'(1);
                state_q <= StData;
              end
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (bus.i_be_fault) begin
            fault_q <= 1'b1;
            stall_q <= 1'b0;
            state_q <= StDone;
          end else if (bus.i_be_rdata_valid) begin
            rdata_q       <= bus.i_be_rdata;
            rdata_valid_q <= 1'b1;
            cnt_q         <= cnt_q + CntW'(1);
            if (last_beat) begin
              stall_q <= 1'b0;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          stall_q <= 1'b1;
          skip_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_dl1_rdata       = rdata_q;
  assign bus.o_dl1_rdata_valid = rdata_valid_q;
  assign bus.o_dl1_tlb_fault   = fault_q;
  assign bus.o_dl1_stall       = stall_q;
  assign bus.o_be_req          = be_req_q;
  assign bus.o_be_adr          = adr_q;
  assign bus.o_be_wen          = wen_q;
  assign bus.o_be_ben          = ben_q;
  assign bus.o_be_wdata        = wdata_q;
  assign bus.o_be_line         = line_q;

  l2c_inv_fifo #(
    .Depth(INV_DEPTH),
    .Width(32)
  ) u_inv_fifo (
    .clk_i  (clk_mc),
    .rst_ni (rst_mc_n),
    .push_i (bus.i_inv_push),
    .data_i (bus.i_inv_adr),
    .full_o (bus.o_inv_full),
    .pop_i  (bus.i_dl1_inv_ack),
    .valid_o(bus.o_dl1_inv_req),
    .data_o (bus.o_dl1_inv_adr)
  );

endmodule

// File: tb/tb_l2c_dl1_port.sv
// Directed bench for l2c_dl1_port: writes, line fills, single reads, faults,
// invalidation queue ordering/overflow and mid-burst reset.
module tb_l2c_dl1_port;

  logic clk_mc = 1'b0;
  logic rst_mc_n;
  int   n_checks = 0;
  int   n_errors = 0;

  l2c_dl1_port_if bus ();

  l2c_dl1_port #(
    .LINE_WORDS(8),
    .INV_DEPTH (4)
  ) u_dut (
    .clk_mc  (clk_mc),
    .rst_mc_n(rst_mc_n),
    .bus     (bus)
  );

  always #5 clk_mc = ~clk_mc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk_mc);
    #1;
  endtask

  task automatic dl1_req(input logic [31:0] adr, input logic [1:0] flags, input logic wen,
                         input logic [3:0] ben, input logic [31:0] wdata);
    bus.i_dl1_adr   = adr;
    bus.i_dl1_flags = flags;
    bus.i_dl1_wen   = wen;
    bus.i_dl1_ben   = ben;
    bus.i_dl1_wdata = wdata;
    bus.i_dl1_valid = 1'b1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d);
    bus.i_be_rdata_valid = v;
    bus.i_be_rdata       = d;
  endtask

  logic [31:0] inv_adrs [5];

  initial begin
    inv_adrs[0] = 32'h0000_1100;
    inv_adrs[1] = 32'h0000_2200;
    inv_adrs[2] = 32'h0000_3300;
    inv_adrs[3] = 32'h0000_4400;
    inv_adrs[4] = 32'h0000_5500;

    rst_mc_n = 1'b0;
    dl1_req(32'h0, 2'b00, 1'b0, 4'h0, 32'h0);
    bus.i_dl1_valid   = 1'b0;
    bus.i_dl1_inv_ack = 1'b0;
    bus.i_be_ack      = 1'b0;
    bus.i_be_fault    = 1'b0;
    beat(1'b0, 32'h0);
    bus.i_inv_adr  = 32'h0;
    bus.i_inv_push = 1'b0;
    tick();
    tick();
    rst_mc_n = 1'b1;

    // Reset state
    check("rst_stall", bus.o_dl1_stall, 1);
    check("rst_be_req", bus.o_be_req, 0);
    check("rst_rvalid", bus.o_dl1_rdata_valid, 0);
    check("rst_fault", bus.o_dl1_tlb_fault, 0);
    check("rst_inv_req", bus.o_dl1_inv_req, 0);
    check("rst_inv_full", bus.o_inv_full, 0);
    check("rst_rdata", bus.o_dl1_rdata, 0);
    check("rst_be_adr", bus.o_be_adr, 0);

    // Uncacheable write, ack after 3 cycles of request
    dl1_req(32'h1000_0004, 2'b01, 1'b1, 4'b0011, 32'h1234_5678);
    tick();
    check("wr_req", bus.o_be_req, 1);
    check("wr_adr", bus.o_be_adr, 32'h1000_0004);
    check("wr_wen", bus.o_be_wen, 1);
    check("wr_ben", bus.o_be_ben, 32'h3);
    check("wr_wdata", bus.o_be_wdata, 32'h1234_5678);
    check("wr_line", bus.o_be_line, 0);
    tick();
    tick();
    check("wr_req_held", bus.o_be_req, 1);
    check("wr_stall_wait", bus.o_dl1_stall, 1);
    bus.i_be_ack = 1'b1;
    tick();
    bus.i_be_ack = 1'b0;
    check("wr_done_stall", bus.o_dl1_stall, 0);
    check("wr_done_req", bus.o_be_req, 0);
    tick();
    // valid still high here must be ignored
    check("wr_post_stall", bus.o_dl1_stall, 1);
    bus.i_dl1_valid = 1'b0;
    tick();
    check("wr_no_reissue", bus.o_be_req, 0);
    check("wr_stall_idle", bus.o_dl1_stall, 1);

    // Cacheable line fill, ack together with beat 0
    dl1_req(32'h2000_0044, 2'b10, 1'b0, 4'hF, 32'h0);
    tick();
    check("lf_req", bus.o_be_req, 1);
    check("lf_adr", bus.o_be_adr, 32'h2000_0040);
    check("lf_line", bus.o_be_line, 1);
    check("lf_wen", bus.o_be_wen, 0);
    bus.i_be_ack = 1'b1;
    beat(1'b1, 32'hA0);
    tick();
    bus.i_be_ack = 1'b0;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("lf_rv%0d", i - 1), bus.o_dl1_rdata_valid, 1);
      check($sformatf("lf_rd%0d", i - 1), bus.o_dl1_rdata, 32'hA0 + 32'(i - 1));
      check($sformatf("lf_st%0d", i - 1), bus.o_dl1_stall, 1);
      beat(1'b1, 32'hA0 + 32'(i));
      tick();
    end
    beat(1'b0, 32'h0);
    check("lf_rv7", bus.o_dl1_rdata_valid, 1);
    check("lf_rd7", bus.o_dl1_rdata, 32'hA7);
    check("lf_st7", bus.o_dl1_stall, 0);
    tick();
    bus.i_dl1_valid = 1'b0;
    check("lf_post_rv", bus.o_dl1_rdata_valid, 0);
    check("lf_post_st", bus.o_dl1_stall, 1);
    tick();

    // Uncacheable single read, minimum latency
    dl1_req(32'h3000_0008, 2'b00, 1'b0, 4'hF, 32'h0);
    tick();
    check("sr_adr", bus.o_be_adr, 32'h3000_0008);
    check("sr_line", bus.o_be_line, 0);
    bus.i_be_ack = 1'b1;
    tick();
    bus.i_be_ack = 1'b0;
    check("sr_req_drop", bus.o_be_req, 0);
    beat(1'b1, 32'hDEAD_BEEF);
    check("sr_stall_wait", bus.o_dl1_stall, 1);
    tick();
    beat(1'b0, 32'h0);
    check("sr_rv", bus.o_dl1_rdata_valid, 1);
    check("sr_rd", bus.o_dl1_rdata, 32'hDEAD_BEEF);
    check("sr_stall", bus.o_dl1_stall, 0);
    tick();
    bus.i_dl1_valid = 1'b0;
    check("sr_post_rv", bus.o_dl1_rdata_valid, 0);
    tick();

    // Line fill faulting after the third beat
    dl1_req(32'h4000_0020, 2'b10, 1'b0, 4'hF, 32'h0);
    tick();
    bus.i_be_ack = 1'b1;
    tick();
    bus.i_be_ack = 1'b0;
    beat(1'b1, 32'hB0);
    tick();
    for (int i = 1; i < 3; i++) begin
      check($sformatf("ft_rd%0d", i - 1), bus.o_dl1_rdata, 32'hB0 + 32'(i - 1));
      beat(1'b1, 32'hB0 + 32'(i));
      tick();
    end
    check("ft_rv2", bus.o_dl1_rdata_valid, 1);
    check("ft_rd2", bus.o_dl1_rdata, 32'hB2);
    beat(1'b0, 32'h0);
    bus.i_be_fault = 1'b1;
    tick();
    bus.i_be_fault = 1'b0;
    check("ft_fault", bus.o_dl1_tlb_fault, 1);
    check("ft_stall", bus.o_dl1_stall, 0);
    check("ft_no_rv", bus.o_dl1_rdata_valid, 0);
    tick();
    bus.i_dl1_valid = 1'b0;
    check("ft_fault_drop", bus.o_dl1_tlb_fault, 0);
    check("ft_post_rv", bus.o_dl1_rdata_valid, 0);
    check("ft_post_st", bus.o_dl1_stall, 1);
    tick();

    // Invalidation queue: five pushes, fifth dropped, FIFO order out
    for (int i = 0; i < 5; i++) begin
      bus.i_inv_push = 1'b1;
      bus.i_inv_adr  = inv_adrs[i];
      tick();
      if (i == 2) check("iq_not_full3", bus.o_inv_full, 0);
      if (i >= 3) check($sformatf("iq_full%0d", i + 1), bus.o_inv_full, 1);
    end
    bus.i_inv_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("iq_req%0d", i), bus.o_dl1_inv_req, 1);
      check($sformatf("iq_adr%0d", i), bus.o_dl1_inv_adr, inv_adrs[i]);
      bus.i_dl1_inv_ack = 1'b1;
      tick();
      bus.i_dl1_inv_ack = 1'b0;
      if (i == 0) check("iq_full_clr", bus.o_inv_full, 0);
    end
    check("iq_empty_req", bus.o_dl1_inv_req, 0);
    // Push and pop together keeps one entry
    bus.i_inv_push = 1'b1;
    bus.i_inv_adr  = 32'h0000_AAA0;
    tick();
    bus.i_inv_adr     = 32'h0000_BBB0;
    bus.i_dl1_inv_ack = 1'b1;
    tick();
    bus.i_inv_push    = 1'b0;
    bus.i_dl1_inv_ack = 1'b0;
    check("iq_pp_req", bus.o_dl1_inv_req, 1);
    check("iq_pp_adr", bus.o_dl1_inv_adr, 32'h0000_BBB0);
    bus.i_dl1_inv_ack = 1'b1;
    tick();
    bus.i_dl1_inv_ack = 1'b0;
    check("iq_pp_empty", bus.o_dl1_inv_req, 0);

    // Reset in the middle of a line fill with an invalidation pending
    bus.i_inv_push = 1'b1;
    bus.i_inv_adr  = 32'h0000_C000;
    tick();
    bus.i_inv_push = 1'b0;
    dl1_req(32'h6000_0000, 2'b10, 1'b0, 4'hF, 32'h0);
    tick();
    bus.i_be_ack = 1'b1;
    tick();
    bus.i_be_ack = 1'b0;
    beat(1'b1, 32'hC0);
    tick();
    check("mr_inv_pending", bus.o_dl1_inv_req, 1);
    beat(1'b1, 32'hC1);
    rst_mc_n        = 1'b0;
    bus.i_dl1_valid = 1'b0;
    tick();
    beat(1'b0, 32'h0);
    check("mr_stall", bus.o_dl1_stall, 1);
    check("mr_be_req", bus.o_be_req, 0);
    check("mr_rv", bus.o_dl1_rdata_valid, 0);
    check("mr_fault", bus.o_dl1_tlb_fault, 0);
    check("mr_inv_req", bus.o_dl1_inv_req, 0);
    check("mr_inv_full", bus.o_inv_full, 0);
    check("mr_rdata", bus.o_dl1_rdata, 0);
    check("mr_be_adr", bus.o_be_adr, 0);
    check("mr_be_line", bus.o_be_line, 0);
    rst_mc_n = 1'b1;
    tick();
    dl1_req(32'h5000_0010, 2'b00, 1'b1, 4'hF, 32'hCAFE_F00D);
    tick();
    check("pr_req", bus.o_be_req, 1);
    check("pr_adr", bus.o_be_adr, 32'h5000_0010);
    check("pr_wdata", bus.o_be_wdata, 32'hCAFE_F00D);
    bus.i_be_ack = 1'b1;
    tick();
    bus.i_be_ack = 1'b0;
    check("pr_stall", bus.o_dl1_stall, 0);
    tick();
    bus.i_dl1_valid = 1'b0;
    check("pr_post_stall", bus.o_dl1_stall, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
